cmult_arbiter: RTL
==================

# cmult_arbiter

Round-robin scheduler that shares one pipelined complex multiplier among K requesters. Each cycle it grants at most one valid request, presents that request's operands to the multiplier, and tracks a requester tag through the multiplier's fixed 4-cycle latency. It then returns the product to the originating requester on a shared result bus with a one-hot valid. It sits between the complex-multiply clients (FFT butterflies, mixers) and the single multiplier instance.

## Interface
- N, 8, operand width; products are 2N bits signed
- K, 4, number of requesters, 2..8
- LAT, 4, multiplier latency in clocks from operand inputs to registered c_r/c_i
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- en  in  1  grant enable; low blocks new grants, in-flight ops still complete
- req_valid  in  K  request valid per requester
- req_ready  out  K  one-hot grant; handshake when req_valid[i] & req_ready[i]
- req_a_r, req_a_i, req_b_r, req_b_i  in  K*N each  packed signed operands, requester i at bits [i*N +: N]
- m_a_r, m_a_i, m_b_r, m_b_i  out  N each  operands to multiplier
- m_c_r, m_c_i  in  2N each  multiplier results
- resp_valid  out  K  one-hot result strobe, registered
- resp_c_r, resp_c_i  out  2N each  result, registered signed
- busy  out  1  any operation in flight (tag pipe or response register)

## Operation
Reset values:
- req_ready=0, resp_valid=0, resp_c_r=resp_c_i=0, busy=0.
- Round-robin pointer ptr=0; all tag-pipe entries invalid.

Arbitration:
- Combinational. Grant the first i with req_valid[i]=1, scanning ptr, ptr+1, … mod K.
- No grant while en=0 or reset=1.
- req_ready depends on req_valid; clients must not make req_valid depend on req_ready.
- On a handshake, ptr <= granted+1 mod K. Otherwise ptr holds.
- Requests are not masked per requester. A requester holding valid continuously gets every K-th slot under full load and every slot when it is alone.

Operands:
- m_* is a combinational mux of the granted requester's operands.
- With no grant, m_* = 0.

Tag pipe:
- LAT-deep shift register of {valid, idx}, where idx is ceil(log2 K) bits.
- Stage 0 loads {handshake, granted idx} each cycle; the pipe shifts every cycle with no stall.

Response:
- When the last tag stage is valid: resp_valid <= onehot(idx), resp_c_r <= m_c_r, resp_c_i <= m_c_i.
- Otherwise resp_valid <= 0 and the data holds its last value.
- Responses have no backpressure; requesters must accept on the strobe.

busy = OR of the tag-pipe valids | (resp_valid != 0).

## Timing
- Handshake at cycle t: multiplier samples operands at the edge ending t. m_c is valid during t+LAT. resp_valid is high during cycle t+LAT+1, so latency is 5 clocks for LAT=4.
- Throughput is one op per clock. Back-to-back grants to different requesters produce back-to-back responses in grant order.
- Simultaneous events:
  - All K valid: grants ptr first.
  - en falling mid-stream: the in-flight LAT ops still deliver; no new grants.
- Reset mid-operation: in-flight ops are discarded, no response is produced for them, and ptr returns to 0. The multiplier is reset by the same signal.
- Widths: operands pass through unmodified; results are 2N-bit signed, with no truncation or saturation.

## Structure
- Shared package cmult_pkg:
  - default N, LAT;
  - IDX_W function (clog2);
  - tag struct {valid, idx}.
- One sub-module: rr_arbiter (K-input round-robin, request vector plus advance strobe, one-hot grant out). It is reusable elsewhere.
- The multiplier is instantiated outside this block. The top-level wrapper connects the m_* ports.

## Test plan
- Single op, requester 2: a=3+4i, b=1+2i, handshake at t=10 -> resp_valid=4'b0100 at t=15, resp_c_r=-5, resp_c_i=10; busy high during t=11..15 only.
- All four requesters valid continuously for 8 cycles, distinct operands -> grants in order 0,1,2,3,0,1,2,3. Responses arrive in the same order, one per cycle, each with the correct product; ptr=0 at the end.
- Only requester 3 valid, then requester 1 joins while 3 is granted -> next grant goes to 1 (ptr wrapped to 0). Thereafter grants alternate 3,1.
- en dropped one cycle after 3 grants -> those 3 responses still arrive; no req_ready while en=0; busy falls after the last response.
- Reset asserted 2 cycles after a grant -> outputs immediately 0 and no resp_valid afterward. After release, the first grant goes to requester 0 if it is valid.
- Extreme values: a=-128-128i, b=-128-128i (N=8) -> resp_c_r=0, resp_c_i=32768 wraps to -32768 in 16 bits, matching the multiplier's native result.

Source files
------------

// File: rtl/cmult_pkg.sv
// cmult_pkg: shared defaults, index-width helper and tag type for the complex-multiplier scheduler
package cmult_pkg;
   localparam int N_DEF     = 8;
   localparam int LAT_DEF   = 4;
   localparam int IDX_MAX_W = 3;

   function automatic int idx_w(input int k);
      return (k <= 2) ? 1 : $clog2(k);
   endfunction

   typedef struct packed {
      logic                 valid;
      logic [IDX_MAX_W-1:0] idx;
   } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: K-input round-robin arbiter, one-hot grant, pointer moves past the winner on advance
module rr_arbiter
   import cmult_pkg::*;
#(
   parameter int K  = 4,
   parameter int IW = idx_w(K)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [K-1:0]  req,
   input  logic          advance,
   output logic [K-1:0]  grant,
   output logic [IW-1:0] grant_idx
);
   logic [IW-1:0] ptr;
   logic [IW-1:0] j;
   logic          hit;

   // first requester at or after ptr, wrapping modulo K
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      hit       = 1'b0;
      j         = '0;
      for (int o = 0; o < K; o++) begin
         j = IW'((int'(ptr) + o) % K);
         if (!hit && req[j]) begin
            hit       = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = j;
         end
      end
   end

   // next search starts one past the requester just served
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr <= '0;
      else if (advance)
         ptr <= (int'(grant_idx) == K - 1) ? '0 : grant_idx + 1'b1;
   end
endmodule

// File: rtl/cmult_arbiter.sv
// cmult_arbiter: shares one LAT-cycle pipelined complex multiplier among K requesters
module cmult_arbiter
   import cmult_pkg::*;
#(
   parameter int N   = N_DEF,
   parameter int K   = 4,
   parameter int LAT = LAT_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   input  logic [K-1:0]   req_valid,
   output logic [K-1:0]   req_ready,
   input  logic [K*N-1:0] req_a_r,
   input  logic [K*N-1:0] req_a_i,
   input  logic [K*N-1:0] req_b_r,
   input  logic [K*N-1:0] req_b_i,
   output logic [N-1:0]   m_a_r,
   output logic [N-1:0]   m_a_i,
   output logic [N-1:0]   m_b_r,
   output logic [N-1:0]   m_b_i,
   input  logic [2*N-1:0] m_c_r,
   input  logic [2*N-1:0] m_c_i,
   output logic [K-1:0]   resp_valid,
   output logic [2*N-1:0] resp_c_r,
   output logic [2*N-1:0] resp_c_i,
   output logic           busy
);
   localparam int IW = idx_w(K);

   logic [K-1:0]       req_m;
   logic [K-1:0]       grant;
   logic [IW-1:0]      gidx;
   logic               hs;
   tag_t [LAT-1:0]     tags;

   assign req_m     = (en && !reset) ? req_valid : '0;
   assign hs        = |grant;
   assign req_ready = grant;

   rr_arbiter #(.K(K), .IW(IW)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (req_m),
      .advance   (hs),
      .grant     (grant),
      .grant_idx (gidx)
   );

   // one-hot OR-mux of the granted operands; zero when nothing is granted
   always_comb begin
      m_a_r = '0;
      m_a_i = '0;
      m_b_r = '0;
      m_b_i = '0;
      for (int i = 0; i < K; i++) begin
         if (grant[i]) begin
            m_a_r = m_a_r | req_a_r[i*N +: N];
            m_a_i = m_a_i | req_a_i[i*N +: N];
            m_b_r = m_b_r | req_b_r[i*N +: N];
            m_b_i = m_b_i | req_b_i[i*N +: N];
         end
      end
   end

   // requester tags ride alongside the multiplier pipeline, never stalling
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tags <= '0;
      else
         tags <= {tags[LAT-2:0], hs, IDX_MAX_W'(gidx)};
   end

   // product is registered back to its originator when its tag leaves the pipe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_valid <= '0;
         resp_c_r   <= '0;
         resp_c_i   <= '0;
      end else if (tags[LAT-1].valid) begin
         resp_valid <= {{(K-1){1'b0}}, 1'b1} << tags[LAT-1].idx;
         resp_c_r   <= m_c_r;
         resp_c_i   <= m_c_i;
      end else begin
         resp_valid <= '0;
      end
   end

   // anything still travelling through the tag pipe or the response register
   always_comb begin
      busy = |resp_valid;
      for (int i = 0; i < LAT; i++)
         busy = busy | tags[i].valid;
   end
endmodule
